// File: rtl/pb_operand_loader.sv
// Push-button operand loader: synchronises and debounces four buttons and a
// 4-bit switch bus, and captures the switches into nibbles of operands a and b.
module pb_operand_loader #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb1,
    input  logic       pb2,
    input  logic       pb3,
    input  logic       pb4,
    input  logic [3:0] q,
    input  logic       clr,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] loaded,
    output logic       ready,
    output logic       load_strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       pb_raw;
    logic [3:0]       pb_m;
    logic [3:0]       pb_s;
    logic [3:0]       q_m;
    logic [3:0]       q_s;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       press;
    logic [7:0]       a_nxt;
    logic [7:0]       b_nxt;
    logic [3:0]       loaded_nxt;

    assign pb_raw = {pb4, pb3, pb2, pb1};

    // Two-flop synchronisers; q bits are synchronised independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_m <= '0;
            pb_s <= '0;
            q_m  <= '0;
            q_s  <= '0;
        end else begin
            pb_m <= pb_raw;
            pb_s <= pb_m;
            q_m  <= q;
            q_s  <= q_m;
        end
    end

    // A press is the edge on which a button's debounced level rises.
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            press[i] = !db[i] && pb_s[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (pb_s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        a_nxt      = a;
        b_nxt      = b;
        loaded_nxt = loaded;
        if (clr) begin
            a_nxt      = '0;
            b_nxt      = '0;
            loaded_nxt = '0;
        end else begin
            if (press[0]) a_nxt[3:0] = q_s;
            if (press[1]) a_nxt[7:4] = q_s;
            if (press[2]) b_nxt[3:0] = q_s;
            if (press[3]) b_nxt[7:4] = q_s;
            loaded_nxt = loaded | press;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            loaded      <= '0;
            ready       <= 1'b0;
            load_strobe <= 1'b0;
        end else begin
            a           <= a_nxt;
            b           <= b_nxt;
            loaded      <= loaded_nxt;
            ready       <= &loaded_nxt;
            load_strobe <= !clr && (|press);
        end
    end

endmodule

// File: tb/tb_pb_operand_loader.sv
// Bench for pb_operand_loader: directed scenarios plus random button activity,
// checked every cycle against a sliding-window reference model.
module tb_pb_operand_loader;

    localparam int DB = 4;
    localparam int L  = DB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0, pb4 = 1'b0;
    logic [3:0] q = '0;
    logic       clr = 1'b0;
    logic [7:0] a, b;
    logic [3:0] loaded;
    logic       ready, load_strobe;

    pb_operand_loader #(.DB_CYCLES(DB), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4),
        .q(q), .clr(clr),
        .a(a), .b(b), .loaded(loaded), .ready(ready), .load_strobe(load_strobe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;

    // Reference: raw input history per edge; a button is "pressed" when the
    // synchronised view (raw delayed two edges) has been high for DB edges.
    logic [3:0] pbh [L];
    logic [3:0] qh  [L];
    logic [3:0] m_db, m_loaded;
    logic [7:0] m_a, m_b;
    logic       m_ready, m_strobe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < L; k++) begin
            pbh[k] = '0;
            qh[k]  = '0;
        end
        m_db = '0; m_loaded = '0; m_a = '0; m_b = '0;
        m_ready = 1'b0; m_strobe = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] pbv, input logic [3:0] qv, input logic clrv);
        logic [3:0] press;
        logic all1, all0;
        for (int k = L - 1; k > 0; k--) begin
            pbh[k] = pbh[k-1];
            qh[k]  = qh[k-1];
        end
        pbh[0] = pbv;
        qh[0]  = qv;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 2; k < L; k++) begin
                if (pbh[k][i]) all0 = 1'b0;
                else           all1 = 1'b0;
            end
            if (!m_db[i] && all1) begin
                m_db[i]  = 1'b1;
                press[i] = 1'b1;
            end else if (m_db[i] && all0) begin
                m_db[i] = 1'b0;
            end
        end
        if (clrv) begin
            m_a = '0; m_b = '0; m_loaded = '0; m_strobe = 1'b0;
        end else if (press != 4'b0000) begin
            if (press[0]) m_a[3:0] = qh[2];
            if (press[1]) m_a[7:4] = qh[2];
            if (press[2]) m_b[3:0] = qh[2];
            if (press[3]) m_b[7:4] = qh[2];
            m_loaded = m_loaded | press;
            m_strobe = 1'b1;
        end else begin
            m_strobe = 1'b0;
        end
        m_ready = &m_loaded;
    endtask

    task automatic step(input logic [3:0] pbv, input logic [3:0] qv, input logic clrv);
        {pb4, pb3, pb2, pb1} = pbv;
        q   = qv;
        clr = clrv;
        @(posedge clk);
        model_edge(pbv, qv, clrv);
        #1;
        check("a", 32'(a), 32'(m_a));
        check("b", 32'(b), 32'(m_b));
        check("loaded", 32'(loaded), 32'(m_loaded));
        check("ready", 32'(ready), 32'(m_ready));
        check("load_strobe", 32'(load_strobe), 32'(m_strobe));
        if (load_strobe) strobes++;
    endtask

    task automatic hold(input logic [3:0] pbv, input logic [3:0] qv, input int n);
        for (int k = 0; k < n; k++) step(pbv, qv, 1'b0);
    endtask

    task automatic press_one(input logic [3:0] pbv, input logic [3:0] qv);
        hold(4'b0000, qv, 2);
        hold(pbv, qv, 10);
        hold(4'b0000, qv, 8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, 32'(a), 32'h0);
        check({tag, "_b"}, 32'(b), 32'h0);
        check({tag, "_loaded"}, 32'(loaded), 32'h0);
        check({tag, "_ready"}, 32'(ready), 32'h0);
        check({tag, "_strobe"}, 32'(load_strobe), 32'h0);
    endtask

    initial begin
        int s0;
        logic [3:0] pbr;
        logic [3:0] qr;
        logic [3:0] bounce;

        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        #3 rst_n = 1'b1;

        // Sequential load
        strobes = 0;
        press_one(4'b0001, 4'b0000);
        check("seq_a0", 32'(a[3:0]), 32'h0);
        check("seq_loaded1", 32'(loaded), 32'h1);
        press_one(4'b0010, 4'b0111);
        check("seq_a", 32'(a), 32'h70);
        press_one(4'b0100, 4'b1111);
        check("seq_b0", 32'(b[3:0]), 32'hF);
        press_one(4'b1000, 4'b0101);
        check("seq_b", 32'(b), 32'h5F);
        check("seq_loaded", 32'(loaded), 32'hF);
        check("seq_ready", 32'(ready), 32'h1);
        check("seq_strobes", 32'(strobes), 32'd4);

        // Bounce rejection, then a clean hold maturing exactly on edge 6
        s0 = strobes;
        hold(4'b0000, 4'b1010, 2);
        bounce = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            bounce[0] = (k == 0 || k == 2 || k == 3 || k == 5 || k == 6 || k == 7);
            step(bounce, 4'b1010, 1'b0);
        end
        check("bounce_a", 32'(a), 32'h70);
        check("bounce_strobes", 32'(strobes), 32'(s0));
        for (int k = 1; k <= 6; k++) begin
            step(4'b0001, 4'b1010, 1'b0);
            check("bounce_edge", 32'(a[3:0]), (k == 6) ? 32'hA : 32'h0);
        end
        hold(4'b0001, 4'b1010, 4);
        hold(4'b0000, 4'b1010, 8);
        check("bounce_one_strobe", 32'(strobes), 32'(s0 + 1));

        // Simultaneous presses
        step(4'b0000, 4'b0011, 1'b1);
        s0 = strobes;
        press_one(4'b0101, 4'b0011);
        check("simul_a", 32'(a), 32'h03);
        check("simul_b", 32'(b), 32'h03);
        check("simul_loaded", 32'(loaded), 32'h5);
        check("simul_ready", 32'(ready), 32'h0);
        check("simul_strobes", 32'(strobes), 32'(s0 + 1));

        // clr on the same edge as a maturing press
        s0 = strobes;
        hold(4'b0000, 4'b1100, 2);
        for (int k = 1; k <= 6; k++) step(4'b0010, 4'b1100, k == 6);
        check("clr_a", 32'(a), 32'h0);
        check("clr_loaded", 32'(loaded), 32'h0);
        check("clr_no_strobe", 32'(load_strobe), 32'h0);
        hold(4'b0010, 4'b1100, 4);
        hold(4'b0000, 4'b1100, 8);
        check("clr_strobes", 32'(strobes), 32'(s0));
        press_one(4'b0010, 4'b1100);
        check("clr_repress_a", 32'(a), 32'hC0);
        check("clr_repress_loaded", 32'(loaded), 32'h2);

        // Async reset in the middle of a pb4 debounce, button kept held
        hold(4'b0000, 4'b1001, 2);
        hold(4'b1000, 4'b1001, 3);
        rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(4'b1000, 4'b1001, 1'b0);
            check("rst_reload", 32'(b[7:4]), (k == 6) ? 32'h9 : 32'h0);
        end
        hold(4'b1000, 4'b1001, 4);
        hold(4'b0000, 4'b1001, 8);

        // Overwrite with all four loaded
        for (int i = 0; i < 4; i++) begin
            pbr = 4'b0001 << i;
            press_one(pbr, 4'($urandom));
        end
        check("ovw_ready_pre", 32'(ready), 32'h1);
        s0 = strobes;
        press_one(4'b0010, 4'b0001);
        check("ovw_a_hi", 32'(a[7:4]), 32'h1);
        check("ovw_ready", 32'(ready), 32'h1);
        check("ovw_strobes", 32'(strobes), 32'(s0 + 1));

        // Random activity
        pbr = '0;
        qr  = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 4) == 0) pbr[i] = ~pbr[i];
            end
            if ($urandom_range(0, 7) == 0) qr = 4'($urandom);
            step(pbr, qr, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pb_operand_loader.md
Name: pb_operand_loader

Overview:
- Front-end stage feeding the nibble comparator (comp_mid).
- Synchronises and debounces four raw push-buttons and the 4-bit switch bus.
- Each debounced press captures the switch value into one nibble of two 8-bit operands: pb1→a[3:0], pb2→a[7:4], pb3→b[3:0], pb4→b[7:4].
- Flags when both operands are complete, so the downstream comparator only sees stable, fully loaded values.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required before the debounced level changes (use 500000 on the board).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pb1, pb2, pb3, pb4  input  1 each  raw, asynchronous, bouncy push-buttons (1 = pressed).
- q  input  4  raw switch value to be captured.
- clr  input  1  synchronous clear of operands and flags.
- a  output  8  operand A.
- b  output  8  operand B.
- loaded  output  4  per-nibble loaded flags; bit i corresponds to pb(i+1).
- ready  output  1  high when loaded == 4'b1111.
- load_strobe  output  1  one-cycle pulse after any nibble update.

Behaviour:
- **Reset (rst_n=0, async):**
  - a=0, b=0, loaded=0, ready=0, load_strobe=0.
  - All synchroniser flops, debounced levels and counters are cleared.
- **Synchronisers:** each pb and each q bit passes through its own 2-flop synchroniser. Only the synchronised values (pbN_s, q_s) are used downstream.
- **Debounce (per button, independent instances):**
  - State is a debounced level db (reset 0) and a counter cnt.
  - If pbN_s == db: cnt ← 0.
  - Else if cnt == DB_CYCLES-1: db ← ~db and cnt ← 0.
  - Else: cnt ← cnt+1.
- **Press event:** occurs on the edge where db toggles 0→1. Releases (1→0) and bounces shorter than DB_CYCLES produce nothing.
- **Capture on a press event:**
  - The target nibble ← q_s, sampled at that same edge.
  - The matching loaded bit ← 1.
  - load_strobe is 1 for exactly the next cycle.
- **Latency:** for a raw press held stable from just before edge 1, the nibble and flag update at edge 2+DB_CYCLES and load_strobe is high for the following cycle. q must be stable for at least 2 cycles before that edge.
- **Re-press:** a repeat press on an already-loaded nibble overwrites it. The loaded bit stays 1 and load_strobe pulses again.
- **Simultaneous presses:** several buttons firing on the same edge all capture the same q_s. A single one-cycle load_strobe is generated.
- **clr:**
  - On an edge with clr=1, a, b and loaded go to 0; debounce state is untouched.
  - clr has priority over a press event on the same edge; that capture is dropped and no load_strobe is generated.
- **ready:** registered, equal to &loaded. It goes high on the same edge that the fourth nibble loads.
- **Reset mid-operation:** clears everything immediately. A button still held after rst_n deasserts is seen as a fresh press; it loads once after 2+DB_CYCLES cycles.
- **Counter range:** cnt never exceeds DB_CYCLES-1; no wrap-around is possible.

Test Plan:
- **Sequential load** (DB_CYCLES=4), each button held 10 cycles:
  - q=0000 then press pb1 → a[3:0]=0.
  - q=0111 then press pb2 → a=8'h70.
  - q=1111 then press pb3 → b[3:0]=F.
  - q=0101 then press pb4 → b=8'h5F, loaded=1111, ready=1.
  - One load_strobe per press, 4 in total.
- **Bounce rejection:** pb1 toggled with 1-, 2- and 3-cycle highs separated by 1-cycle lows, q=1010 → a, loaded and load_strobe unchanged. Then hold 6 cycles → a[3:0]=A exactly at edge 6, one strobe.
- **Simultaneous presses:** pb1 and pb3 pressed on the same edge with q=0011 → a[3:0]=3, b[3:0]=3, loaded=0101, single load_strobe, ready=0.
- **clr priority:** assert clr on the edge pb2's press matures (q=1100) → a=0, loaded=0000, no strobe. Release and re-press pb2 → a[7:4]=C.
- **Async reset mid-debounce:** pulse rst_n low at cycle 3 of a pb4 hold (q=1001) → outputs 0 immediately. Keep pb4 held → b[7:4]=9 at 2+DB_CYCLES edges after rst_n rises.
- **Overwrite:** with ready=1, press pb2 with q=0001 → a[7:4]=1, ready stays 1, one strobe.
